// File: rtl/i2c_pkg.sv
// Shared constants for the write-only I2C target receiver.
// The FSM state encodings are plain localparams so older code that compares raw state values still works.
package i2c_pkg;

    localparam int BIT_CNT_W = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_ACK    = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_IGNORE = 3'd4;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [6:0] OLED_I2C_ADDR = 7'h3C;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser for one asynchronous bus line.
// It also keeps the previous synchronised sample so it can report the line level plus one-cycle rise and fall pulses.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], line_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to 1 so an idle (pulled-up) bus produces no spurious edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver.
// It matches a 7-bit address, ACKs write transfers and delivers each received data byte as a one-cycle strobe.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = OLED_I2C_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       rx_ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .line_in (scl_in),
        .level   (scl_level),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .line_in (sda_in),
        .level   (sda_level),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    logic [2:0]           state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           data_out_q, data_out_d;
    logic                 sda_oe_q, sda_oe_d;
    logic                 data_valid_q, data_valid_d;
    logic                 start_det_q, start_det_d;
    logic                 stop_det_q, stop_det_d;
    logic                 busy_q, busy_d;

    logic       start_cond;
    logic       stop_cond;
    logic [7:0] shifted;
    logic       last_bit;

    assign start_cond = sda_fall & scl_level;
    assign stop_cond  = sda_rise & scl_level;
    assign shifted    = {shift_q[6:0], sda_level};
    assign last_bit   = (bit_cnt_q == BIT_CNT_W'(7));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        sda_oe_d     = sda_oe_q;
        busy_d       = busy_q;
        data_valid_d = 1'b0;
        start_det_d  = 1'b0;
        stop_det_d   = 1'b0;

        if (start_cond) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = '0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            start_det_d = 1'b1;
        end else if (stop_cond) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit) begin
                            if (shifted[7:1] == ADDR && shifted[0] == 1'b0) begin
                                state_d = ST_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                // The first SCL fall after the 8th bit starts driving the ACK.
                // The next SCL fall, after the 9th clock, ends it.
                ST_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (scl_rise) begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit) begin
                            if (rx_ready) begin
                                data_out_d   = shifted;
                                data_valid_d = 1'b1;
                                state_d      = ST_ACK;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            sda_oe_q     <= 1'b0;
            data_valid_q <= 1'b0;
            start_det_q  <= 1'b0;
            stop_det_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            sda_oe_q     <= sda_oe_d;
            data_valid_q <= data_valid_d;
            start_det_q  <= start_det_d;
            stop_det_q   <= stop_det_d;
            busy_q       <= busy_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign start_det  = start_det_q;
    assign stop_det   = stop_det_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx.
// A bit-banged I2C controller drives the bus; open-drain SDA is modelled as the AND of controller and target.
module tb_i2c_target_rx;

    localparam int Q    = 10;
    localparam int HALF = 2 * Q;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_in = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic       rx_ready = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       start_det;
    logic       stop_det;
    logic       busy;

    int         testsRun = 0;
    int         testsFailed = 0;
    int         validCount = 0;
    int         startCount = 0;
    int         stopCount = 0;
    logic       oeEver = 1'b0;
    logic [7:0] dataLog [0:7];
    logic       ackSeen;

    assign sda_in = sda_m & ~sda_oe;

    always #5 clock = ~clock;

    i2c_target_rx #(.ADDR(7'h3C), .SYNC_STAGES(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .sda_oe     (sda_oe),
        .rx_ready   (rx_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .busy       (busy)
    );

    // Event log sampled on the falling system-clock edge, away from the DUT's active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (data_valid) begin
                if (validCount < 8) dataLog[validCount] = data_out;
                validCount = validCount + 1;
            end
            if (start_det) startCount = startCount + 1;
            if (stop_det)  stopCount  = stopCount + 1;
            if (sda_oe)    oeEver     = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun = testsRun + 1;
        if (got !== exp) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clearLog();
        validCount = 0;
        startCount = 0;
        stopCount  = 0;
        oeEver     = 1'b0;
    endtask

    task automatic i2cStart();
        sda_m = 1'b1;
        waitCycles(Q);
        scl_in = 1'b1;
        waitCycles(Q);
        sda_m = 1'b0;
        waitCycles(Q);
        scl_in = 1'b0;
        waitCycles(Q);
    endtask

    task automatic i2cStop();
        sda_m = 1'b0;
        waitCycles(Q);
        scl_in = 1'b1;
        waitCycles(Q);
        sda_m = 1'b1;
        waitCycles(HALF);
    endtask

    task automatic writeBit(input logic b);
        sda_m = b;
        waitCycles(Q);
        scl_in = 1'b1;
        waitCycles(HALF);
        scl_in = 1'b0;
        waitCycles(Q);
    endtask

    // Sends eight bits, then releases SDA for the 9th clock and samples sda_oe while SCL is high.
    task automatic applyStimulus(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) writeBit(b[i]);
        sda_m = 1'b1;
        waitCycles(Q);
        scl_in = 1'b1;
        waitCycles(Q);
        ack = sda_oe;
        waitCycles(Q);
        scl_in = 1'b0;
        waitCycles(Q);
    endtask

    initial begin
        waitCycles(3);
        checkOutput("rst_sda_oe", sda_oe, 0);
        checkOutput("rst_data_out", data_out, 0);
        checkOutput("rst_data_valid", data_valid, 0);
        checkOutput("rst_start_det", start_det, 0);
        checkOutput("rst_stop_det", stop_det, 0);
        checkOutput("rst_busy", busy, 0);
        reset_n = 1'b1;
        waitCycles(5);

        $display("[TB] address match");
        clearLog();
        i2cStart();
        checkOutput("m_start_cnt", startCount, 1);
        applyStimulus(8'h78, ackSeen);
        checkOutput("m_addr_ack", ackSeen, 1);
        checkOutput("m_busy", busy, 1);
        applyStimulus(8'hAA, ackSeen);
        checkOutput("m_ack_aa", ackSeen, 1);
        applyStimulus(8'h11, ackSeen);
        checkOutput("m_ack_11", ackSeen, 1);
        checkOutput("m_busy_pre_stop", busy, 1);
        i2cStop();
        checkOutput("m_valid_cnt", validCount, 2);
        checkOutput("m_byte0", dataLog[0], 8'hAA);
        checkOutput("m_byte1", dataLog[1], 8'h11);
        checkOutput("m_start_total", startCount, 1);
        checkOutput("m_stop_cnt", stopCount, 1);
        checkOutput("m_busy_after", busy, 0);
        checkOutput("m_oe_after", sda_oe, 0);

        $display("[TB] address mismatch");
        clearLog();
        i2cStart();
        applyStimulus(8'h7A, ackSeen);
        checkOutput("x_addr_ack", ackSeen, 0);
        checkOutput("x_busy", busy, 0);
        applyStimulus(8'h55, ackSeen);
        checkOutput("x_data_ack", ackSeen, 0);
        i2cStop();
        checkOutput("x_oe_ever", oeEver, 0);
        checkOutput("x_valid_cnt", validCount, 0);
        checkOutput("x_stop_cnt", stopCount, 1);
        checkOutput("x_data_out", data_out, 8'h11);

        $display("[TB] read request");
        clearLog();
        i2cStart();
        applyStimulus(8'h79, ackSeen);
        checkOutput("r_addr_ack", ackSeen, 0);
        checkOutput("r_busy", busy, 0);
        applyStimulus(8'h78, ackSeen);
        checkOutput("r_ignored_ack", ackSeen, 0);
        i2cStop();
        checkOutput("r_valid_cnt", validCount, 0);
        checkOutput("r_oe_ever", oeEver, 0);

        $display("[TB] sink not ready");
        clearLog();
        i2cStart();
        applyStimulus(8'h78, ackSeen);
        checkOutput("n_addr_ack", ackSeen, 1);
        rx_ready = 1'b0;
        applyStimulus(8'hC3, ackSeen);
        checkOutput("n_data_nack", ackSeen, 0);
        rx_ready = 1'b1;
        applyStimulus(8'h44, ackSeen);
        checkOutput("n_follow_nack", ackSeen, 0);
        checkOutput("n_busy_held", busy, 1);
        i2cStop();
        checkOutput("n_valid_cnt", validCount, 0);
        checkOutput("n_data_out", data_out, 8'h11);

        $display("[TB] repeated start mid-byte");
        clearLog();
        i2cStart();
        applyStimulus(8'h78, ackSeen);
        checkOutput("s_addr1_ack", ackSeen, 1);
        writeBit(1'b1);
        writeBit(1'b0);
        writeBit(1'b1);
        writeBit(1'b1);
        i2cStart();
        checkOutput("s_start_cnt", startCount, 2);
        checkOutput("s_busy_cleared", busy, 0);
        applyStimulus(8'h78, ackSeen);
        checkOutput("s_addr2_ack", ackSeen, 1);
        applyStimulus(8'h5A, ackSeen);
        checkOutput("s_data_ack", ackSeen, 1);
        i2cStop();
        checkOutput("s_valid_cnt", validCount, 1);
        checkOutput("s_byte0", dataLog[0], 8'h5A);
        checkOutput("s_stop_cnt", stopCount, 1);

        $display("[TB] reset during ack");
        clearLog();
        i2cStart();
        for (int i = 7; i >= 0; i--) writeBit(i == 6 ? 1'b1 : (i >= 3 && i <= 5 ? 1'b1 : 1'b0));
        sda_m = 1'b1;
        waitCycles(Q);
        scl_in = 1'b1;
        waitCycles(Q);
        checkOutput("a_oe_before", sda_oe, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("a_oe_async", sda_oe, 0);
        checkOutput("a_busy", busy, 0);
        checkOutput("a_data_out", data_out, 0);
        waitCycles(Q);
        scl_in = 1'b0;
        waitCycles(Q);
        scl_in = 1'b1;
        waitCycles(Q);
        reset_n = 1'b1;
        waitCycles(Q);
        scl_in = 1'b0;
        waitCycles(Q);
        applyStimulus(8'h78, ackSeen);
        checkOutput("a_no_start_ack", ackSeen, 0);
        checkOutput("a_idle_busy", busy, 0);
        i2cStart();
        applyStimulus(8'h78, ackSeen);
        checkOutput("a_restart_ack", ackSeen, 1);
        i2cStop();
        checkOutput("a_busy_end", busy, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- Write-only I2C target (slave) receiver; the far end of our I2C command transmitter on the OLED link.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address, ACKs by pulling SDA low, and delivers each received data byte as a one-cycle strobe.
- Used as the bench-side display model and as the front end of an on-chip display-controller emulator.

Parameters:
- ADDR, 7'h3C, 7-bit target address (SSD1306 default).
- SYNC_STAGES, 2, flops in the SCL/SDA input synchroniser (min 2).

Ports:
- clock  in  1  system clock; must be at least 8x the SCL rate.
- reset_n  in  1  asynchronous, active-low reset.
- scl_in  in  1  SCL pad input (asynchronous).
- sda_in  in  1  SDA pad input (asynchronous).
- sda_oe  out  1  1 = drive SDA low (open-drain); 0 = release.
- rx_ready  in  1  sink can accept a byte; sampled at the 8th data bit.
- data_out  out  8  last accepted data byte, MSB first on the wire.
- data_valid  out  1  one-cycle strobe, data_out valid.
- start_det  out  1  one-cycle pulse on START or repeated START.
- stop_det  out  1  one-cycle pulse on STOP.
- busy  out  1  high from an address match until STOP or START.

Behaviour:
- Reset values: sda_oe=0, data_out=0, data_valid=0, start_det=0, stop_det=0, busy=0, state=IDLE, bit counter=0, synchronisers=1 (bus idle).
- Reset is asynchronous: sda_oe drops on the same edge as reset_n, including mid-ACK.
- Inputs are synchronised, and edges are detected against the previous synchronised sample. All events below refer to synchronised signals, so latency from the pad is SYNC_STAGES+1 cycles.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both have priority over bit shifting in the same cycle.
- A START in any state (including mid-byte or mid-ACK) releases sda_oe, clears the bit counter, pulses start_det, clears busy and goes to ADDR.
- A STOP in any state releases sda_oe, pulses stop_det, clears busy and goes to IDLE.
- Bits are sampled on the SCL rising edge into an 8-bit shift register, MSB first; the counter runs 0..7.
- State machine:
  - IDLE: ignore everything except START.
  - ADDR: after 8 bits, if shift[7:1]==ADDR and shift[0]==0 (write), set ack_pending=1 and busy=1; otherwise go to IGNORE.
  - ADDR read (shift[0]==1) to our address is NACKed and goes to IGNORE.
  - ACK: on the first SCL falling edge after the 8th bit, drive sda_oe=1. Hold it through the 9th SCL rising edge. Release it on the next SCL falling edge, then go to DATA with the counter at 0.
  - DATA, on the 8th rising edge:
    - If rx_ready=1: data_out<=byte, data_valid=1 in that cycle, then ACK.
    - If rx_ready=0: byte dropped, no strobe, NACK (sda_oe stays 0). Go to IGNORE.
  - IGNORE: sda_oe=0; wait for START or STOP.
- sda_oe changes only on synchronised SCL falling edges while SCL is low, so SDA never changes during SCL high.
- Exceptions to the SCL-low rule: reset, and release on START/STOP.
- data_valid, start_det and stop_det never overlap for the same event and are never asserted for more than one cycle.
- Clock stretching is not supported; SCL is never driven.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, ADDR, ACK, DATA, IGNORE).
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1, OLED_I2C_ADDR=7'h3C.
  - bit-count width.
- One sub-module, i2c_line_sync: SYNC_STAGES synchroniser plus previous-sample register for one line. Outputs level, rise and fall. Instantiated twice (SCL, SDA).

Test Plan:
- Address match: START, 0x78, 0xAA, 0x11, STOP at 100 kHz-equivalent with rx_ready=1 → sda_oe high during all 3 ninth clocks; data_valid pulses twice with data_out=0xAA then 0x11; one start_det, one stop_det; busy high between them.
- Address mismatch: START, 0x7A, 0x55, STOP → sda_oe never asserted, no data_valid, busy stays 0, stop_det pulses.
- Read request: START, 0x79 → NACK on the 9th clock; state IGNORE until STOP; no data_valid.
- Sink not ready: START, 0x78 (ACKed), 0xC3 with rx_ready=0 → NACK on the 9th clock, no data_valid, data_out keeps its previous value; a following byte is ignored.
- Repeated START mid-byte: START, 0x78 (ACK), 4 bits of data, repeated START, 0x78, 0x5A, STOP → second start_det, partial byte discarded, single data_valid with 0x5A.
- Reset during ACK: assert reset_n=0 while sda_oe=1 → sda_oe=0 asynchronously, all outputs at reset values. After release, the bus is idle until the next START.
